rm_report_collector_c3: RTL and testbench
=========================================

RM_REPORT_COLLECTOR_C3 -- requirements
Module: rm_report_collector_c3

Interface
REQ-001 SHALL have parameter NUM_REPORTS, default 40, meaning report bits received per cycle from the cluster-3 stage.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, a power of two, meaning number of buffered report records.
REQ-003 SHALL have parameter CYCLE_W, default 32, meaning width of the free-running cycle stamp.
REQ-004 SHALL have port clk  input  1  as the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port reset  input  1  as the reset, which is asynchronous and active-high.
REQ-006 SHALL have port run  input  1  as the stage-advance qualifier, the same signal that drives the automata stage.
REQ-007 SHALL have port clear  input  1  as a synchronous flush of the FIFO, cycle counter and drop counter.
REQ-008 SHALL have port reports  input  NUM_REPORTS  as the concatenated automata report outputs, ltl0c3 first in the LSBs, w_out ascending.
REQ-009 SHALL have port symbol  input  8  as the symbol byte the reports refer to, i.e. top_symbols of the same cycle.
REQ-010 SHALL have port rec_valid  output  1  as the record-available flag.
REQ-011 SHALL have port rec_ready  input  1  as the consumer-accept flag.
REQ-012 SHALL have port rec_data  output  CYCLE_W+8+NUM_REPORTS  carrying {cycle, symbol, reports}, with reports in the LSBs.
REQ-013 SHALL have port overflow  output  1  as a sticky flag meaning a record was dropped.
REQ-014 SHALL have port drop_count  output  16  as the saturating count of dropped records.
REQ-015 SHALL have port fill  output  $clog2(FIFO_DEPTH)+1  as the current FIFO occupancy.

Function
REQ-016 Cycle counter SHALL increment by 1 on each clk with run=1, hold when run=0, and wrap from 2^CYCLE_W-1 to 0.
REQ-017 Capture (push) SHALL occur when run=1 and reports!=0; the record SHALL hold the counter value before that cycle's increment.
REQ-018 Cycles with run=0 or reports==0 SHALL NOT push.
REQ-019 Latency: a record pushed into an empty FIFO at edge N SHALL appear with rec_valid=1 after edge N; there is no combinational input-to-output path.
REQ-020 A transfer SHALL occur when rec_valid and rec_ready are both 1 at a rising edge.
REQ-021 rec_data SHALL stay stable while rec_valid=1 and rec_ready=0.
REQ-022 rec_valid SHALL NOT depend on rec_ready.
REQ-023 Records SHALL pop in push order.
REQ-024 Empty FIFO: rec_valid SHALL be 0, rec_data SHALL be don't-care, and rec_ready SHALL be ignored.
REQ-025 Full FIFO, push with no pop at the same edge: the record SHALL be dropped, overflow SHALL be set to 1, drop_count SHALL increment, and the FIFO contents SHALL be unchanged.
REQ-026 Full FIFO, push and pop at the same edge: both SHALL occur, no drop SHALL be recorded, and fill SHALL be unchanged.
REQ-027 Push and pop at the same edge on a non-empty, non-full FIFO SHALL leave fill unchanged.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-029 drop_count SHALL saturate at 16'hFFFF.
REQ-030 overflow SHALL clear only on reset or clear.
REQ-031 clear=1 SHALL, at the edge, empty the FIFO and zero the cycle counter, drop_count and overflow, and SHALL suppress any push or pop at that edge.

Reset
REQ-032 On reset=1, asynchronously: rec_valid=0, fill=0, overflow=0, drop_count=0, cycle counter=0, pointers=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered records, and no partial record SHALL be emitted after release.
REQ-034 FIFO storage need not be reset.

Structure
REQ-035 Shared package rm_report_pkg SHALL hold the NUM_REPORTS/CYCLE_W defaults and the record-width constant.
REQ-036 FIFO storage and pointers SHALL be one sub-module, rm_report_fifo, a synchronous single-clock show-ahead FIFO with a registered output.
REQ-037 The top level SHALL contain only the cycle counter, capture logic, drop/overflow logic and the sub-module instance.

Verification
REQ-038 Reset; run=1 for 5 cycles with reports=0, then reports=40'h1 with symbol=8'h41, rec_ready=1 -> one record, cycle=5, symbol=8'h41, reports=1, valid one cycle after capture.
REQ-039 rec_ready=0; push 16 records, then a 17th -> fill=16, overflow=1, drop_count=1; draining returns records 0..15 in order.
REQ-040 Full FIFO, rec_ready=1 and push at the same edge -> fill stays 16, overflow stays 0, drop_count=0.
REQ-041 Toggle run 1/0 alternately, pushing each run cycle -> consecutive cycle stamps differ by exactly 1; run=0 cycles produce no records.
REQ-042 Preload counter to 32'hFFFFFFFF via a force, push two records -> stamps FFFFFFFF then 0.
REQ-043 Assert reset and, separately, clear with 8 records buffered and rec_valid=1 -> fill=0, rec_valid=0, overflow=0 (same cycle for reset, next edge for clear).

Source files
------------

// File: rtl/rm_report_pkg.sv
// Shared constants for the cluster-3 report collector.
//   NUM_REPORTS_DEF : default number of report bits captured per cycle
//   CYCLE_W_DEF     : default width of the free-running cycle stamp
//   SYMBOL_W        : width of the symbol byte stored with each record
//   REC_W_DEF       : record width for the default configuration
//   rec_width()     : record width {cycle, symbol, reports} for any configuration
package rm_report_pkg;

    localparam int NUM_REPORTS_DEF = 40;
    localparam int CYCLE_W_DEF     = 32;
    localparam int SYMBOL_W        = 8;
    localparam int REC_W_DEF       = CYCLE_W_DEF + SYMBOL_W + NUM_REPORTS_DEF;

    function automatic int rec_width(input int cycle_w, input int num_reports);
        return cycle_w + SYMBOL_W + num_reports;
    endfunction

endpackage

// File: rtl/rm_report_fifo.sv
// Single-clock show-ahead FIFO with a registered head-of-queue output.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (pointers only)
//   flush           : synchronous empty; overrides push and pop at that edge
//   push, wdata     : write request and data (ignored when full unless popping)
//   pop             : read accept (ignored when empty)
//   valid, rdata    : head record available / head record
//   full            : occupancy equals DEPTH
//   fill            : current occupancy, 0..DEPTH
module rm_report_fifo
    import rm_report_pkg::*;
#(
    parameter int W     = REC_W_DEF,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic                     valid,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   rd_nxt;
    logic [AW:0]   cnt_after_pop;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    // Extra MSB on each pointer tells full (MSBs differ) from empty (equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a write when the head leaves at the same edge.
    assign do_push = push && (!full || do_pop) && !flush;

    assign rd_nxt        = rd_ptr + (AW+1)'(do_pop);
    assign cnt_after_pop = count - (AW+1)'(do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head register holds the entry rd_nxt will point at. If nothing is left
    // after the pop, the incoming write becomes the head and is bypassed in;
    // otherwise the next entry is already in storage. Contents are don't-care
    // while empty, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && (cnt_after_pop == '0))
            head <= wdata;
        else
            head <= mem[rd_nxt[AW-1:0]];
    end

    assign valid = !empty;
    assign rdata = head;
    assign fill  = count;

endmodule

// File: rtl/rm_report_collector_c3.sv
// Cluster-3 report collector: stamps non-zero report vectors with a cycle
// count and the current symbol, and buffers them for a ready/valid consumer.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   run         : stage-advance qualifier (counter and capture only when 1)
//   clear       : synchronous flush of FIFO, cycle counter, drop count, overflow
//   reports     : automata report bits, ltl0c3 in the LSBs
//   symbol      : symbol byte the reports belong to
//   rec_valid / rec_ready / rec_data : record stream {cycle, symbol, reports}
//   overflow    : sticky, a record was dropped since reset/clear
//   drop_count  : saturating count of dropped records
//   fill        : FIFO occupancy
module rm_report_collector_c3
    import rm_report_pkg::*;
#(
    parameter int NUM_REPORTS = NUM_REPORTS_DEF,
    parameter int FIFO_DEPTH  = 16,
    parameter int CYCLE_W     = CYCLE_W_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 run,
    input  logic                                 clear,
    input  logic [NUM_REPORTS-1:0]               reports,
    input  logic [7:0]                           symbol,
    output logic                                 rec_valid,
    input  logic                                 rec_ready,
    output logic [CYCLE_W+8+NUM_REPORTS-1:0]     rec_data,
    output logic                                 overflow,
    output logic [15:0]                          drop_count,
    output logic [$clog2(FIFO_DEPTH):0]          fill
);

    localparam int REC_W = rec_width(CYCLE_W, NUM_REPORTS);

    logic [CYCLE_W-1:0] cycle;
    logic [CYCLE_W-1:0] cycle_nxt;
    logic [15:0]        drop_cnt;
    logic [15:0]        drop_nxt;
    logic               ovf;
    logic               ovf_nxt;
    logic               push_req;
    logic               pop_req;
    logic               drop;
    logic               full;
    logic [REC_W-1:0]   wrec;

    // Capture uses the pre-increment stamp.
    assign wrec     = {cycle, symbol, reports};
    assign push_req = run && (|reports) && !clear;
    assign pop_req  = rec_valid && rec_ready && !clear;
    assign drop     = push_req && full && !pop_req;

    // Next-state values are registered unconditionally every edge so that
    // holding is an explicit assignment of the current value.
    always_comb begin
        cycle_nxt = cycle;
        drop_nxt  = drop_cnt;
        ovf_nxt   = ovf;
        if (clear) begin
            cycle_nxt = '0;
            drop_nxt  = '0;
            ovf_nxt   = 1'b0;
        end else begin
            if (run)
                cycle_nxt = cycle + CYCLE_W'(1);
            if (drop) begin
                ovf_nxt = 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_nxt = drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle    <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            cycle    <= cycle_nxt;
            drop_cnt <= drop_nxt;
            ovf      <= ovf_nxt;
        end
    end

    rm_report_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .flush (clear),
        .push  (push_req),
        .wdata (wrec),
        .pop   (pop_req),
        .valid (rec_valid),
        .rdata (rec_data),
        .full  (full),
        .fill  (fill)
    );

    assign overflow   = ovf;
    assign drop_count = drop_cnt;

endmodule

// File: tb/tb_rm_report_collector_c3.sv
// Bench for rm_report_collector_c3: the driver pushes expected records into a
// queue; a monitor pops and compares on every accepted transfer.
module tb_rm_report_collector_c3;

    localparam int NR = 40;
    localparam int D  = 16;
    localparam int CW = 32;
    localparam int RW = CW + 8 + NR;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          clear;
    logic [NR-1:0] reports;
    logic [7:0]    symbol;
    logic          rec_valid;
    logic          rec_ready;
    logic [RW-1:0] rec_data;
    logic          overflow;
    logic [15:0]   drop_count;
    logic [4:0]    fill;

    rm_report_collector_c3 #(.NUM_REPORTS(NR), .FIFO_DEPTH(D), .CYCLE_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .clear      (clear),
        .reports    (reports),
        .symbol     (symbol),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_data   (rec_data),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fill       (fill)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] q[$];
    int            mcnt;
    logic [CW-1:0] cyc;
    logic [15:0]   mdrop;
    logic          movf;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic state_chk(input string nm);
        chk({nm, "_fill"}, RW'(fill), RW'(mcnt));
        chk({nm, "_ovf"},  RW'(overflow), RW'(movf));
        chk({nm, "_drop"}, RW'(drop_count), RW'(mdrop));
    endtask

    task automatic model_flush();
        q.delete();
        mcnt  = 0;
        cyc   = '0;
        mdrop = '0;
        movf  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, wait for the edge, settle.
    task automatic step(input logic r, input logic [NR-1:0] rep, input logic [7:0] sym);
        bit p_pop;
        bit p_push;
        run     = r;
        reports = rep;
        symbol  = sym;
        p_pop   = rec_ready && (mcnt > 0);
        p_push  = r && (rep != '0);
        if (p_push) begin
            if (mcnt == D && !p_pop) begin
                movf = 1'b1;
                if (mdrop != 16'hFFFF) mdrop++;
            end else begin
                q.push_back({cyc, sym, rep});
                mcnt++;
            end
        end
        if (p_pop) mcnt--;
        if (r) cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear   = 1'b1;
        run     = 1'b1;
        reports = 40'hDEAD;
        symbol  = 8'h99;
        @(posedge clk);
        #1;
        clear = 1'b0;
        run   = 1'b0;
        model_flush();
    endtask

    // Monitor: an accepted transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset && !clear && rec_valid === 1'b1 && rec_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rec got %h want none", rec_data);
            end else begin
                chk("rec_data", rec_data, q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        clear     = 1'b0;
        reports   = '0;
        symbol    = '0;
        rec_ready = 1'b0;
        model_flush();
        #2;
        chk("rst_valid", RW'(rec_valid), '0);
        state_chk("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // First capture after five empty run cycles carries stamp 5.
        rec_ready = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, '0, 8'h00);
        chk("idle_no_valid", RW'(rec_valid), '0);
        step(1'b1, 40'h1, 8'h41);
        chk("lat_valid", RW'(rec_valid), RW'(1));
        chk("first_rec", rec_data, {32'd5, 8'h41, 40'h1});
        step(1'b0, '0, 8'h00);
        chk("drained_valid", RW'(rec_valid), '0);

        // Fill to 16, overflow on the 17th, then drain in order.
        rec_ready = 1'b0;
        for (int i = 0; i < D; i++) step(1'b1, NR'(i + 1), 8'(8'h10 + i));
        state_chk("full16");
        step(1'b1, 40'hFF, 8'hEE);
        chk("ovf_fill", RW'(fill), RW'(16));
        chk("ovf_flag", RW'(overflow), RW'(1));
        chk("ovf_drop", RW'(drop_count), RW'(1));
        // Saturation: preload drop counter to FFFF, drop once more.
        run     = 1'b0;
        reports = '0;
        force dut.drop_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.drop_cnt;
        mdrop = 16'hFFFF;
        step(1'b1, 40'h77, 8'h01);
        chk("drop_sat", RW'(drop_count), RW'(16'hFFFF));
        rec_ready = 1'b1;
        for (int i = 0; i < D; i++) step(1'b0, '0, 8'h00);
        state_chk("drain16");
        chk("ovf_sticky", RW'(overflow), RW'(1));

        // Full FIFO with simultaneous push and pop: no drop.
        do_clear();
        state_chk("clr");
        rec_ready = 1'b0;
        for (int i = 0; i < D; i++) step(1'b1, NR'(40'h100 + i), 8'(8'h20 + i));
        rec_ready = 1'b1;
        step(1'b1, 40'hAA, 8'h5A);
        chk("pp_fill", RW'(fill), RW'(16));
        chk("pp_ovf", RW'(overflow), '0);
        chk("pp_drop", RW'(drop_count), '0);
        for (int i = 0; i < D + 1; i++) step(1'b0, '0, 8'h00);
        state_chk("pp_drain");

        // Alternating run: stamps advance only on run cycles.
        for (int i = 0; i < 10; i++) step(i[0] == 1'b0, NR'(40'h3 + i), 8'(8'h60 + i));
        step(1'b0, '0, 8'h00);
        state_chk("toggle");

        // Counter wrap: hold at FFFFFFFF through one run=0 edge, then push two.
        run     = 1'b0;
        reports = '0;
        force dut.cycle = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        release dut.cycle;
        cyc = 32'hFFFFFFFF;
        step(1'b1, 40'h11, 8'hA1);
        chk("wrap_first", rec_data, {32'hFFFFFFFF, 8'hA1, 40'h11});
        step(1'b1, 40'h22, 8'hA2);
        chk("wrap_second", rec_data, {32'h0, 8'hA2, 40'h22});
        step(1'b0, '0, 8'h00);

        // Clear with 8 buffered.
        rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, NR'(i + 1), 8'h30);
        chk("pre_clr_valid", RW'(rec_valid), RW'(1));
        chk("pre_clr_fill", RW'(fill), RW'(8));
        rec_ready = 1'b1;
        do_clear();
        chk("clr_valid", RW'(rec_valid), '0);
        state_chk("clr8");

        // Reset mid-cycle with 8 buffered.
        rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, NR'(i + 9), 8'h40);
        chk("pre_rst_valid", RW'(rec_valid), RW'(1));
        #2;
        reset = 1'b1;
        #1;
        model_flush();
        chk("rst_mid_valid", RW'(rec_valid), '0);
        state_chk("rst_mid");
        @(posedge clk);
        #1;
        reset     = 1'b0;
        rec_ready = 1'b1;
        step(1'b0, '0, 8'h00);
        chk("post_rst_valid", RW'(rec_valid), '0);
        step(1'b1, 40'h5, 8'h77);
        chk("post_rst_rec", rec_data, {32'h0, 8'h77, 40'h5});
        step(1'b0, '0, 8'h00);
        step(1'b0, '0, 8'h00);
        state_chk("final");
        chk("q_empty", RW'(q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
